// File: rtl/branch_predictor_table_pkg.sv
// Shared types and counter helpers for the branch direction predictor.
// The helpers take the counter width as an argument so one package serves any CTR_W.
package bp_pkg;

  typedef enum logic {INIT, READY} bp_state_t;

  function automatic logic [31:0] sat_next(input logic [31:0] c, input logic taken,
                                           input int ctr_w);
    logic [31:0] max_v;
    max_v = (32'd1 << ctr_w) - 32'd1;
    if (taken) return (c >= max_v) ? max_v : c + 32'd1;
    return (c == 32'd0) ? 32'd0 : c - 32'd1;
  endfunction

  // The midpoint counter is the weakly-undecided state.
  // The backward-branch hint only breaks the tie there.
  function automatic logic predict(input logic [31:0] c, input logic back,
                                   input int ctr_w, input logic back_hint);
    logic [31:0] mid_v;
    mid_v = 32'd1 << (ctr_w - 1);
    return (c > mid_v) || ((c == mid_v) && back && back_hint);
  endfunction

endpackage

// File: rtl/branch_predictor_table_sat_ctr.sv
// Next-value logic for one saturating counter on the training path.
module bp_sat_ctr
  import bp_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr,
  input  logic             taken,
  output logic [CTR_W-1:0] ctr_next
);

  assign ctr_next = CTR_W'(sat_next(32'(ctr), taken, CTR_W));

endmodule

// File: rtl/branch_predictor_table.sv
// Bimodal / gshare direction predictor: table of saturating counters with a
// registered one-cycle lookup, training port and a post-reset init sweep.
module branch_predictor_table
  import bp_pkg::*;
#(
  parameter int INDEX_W   = 6,
  parameter int CTR_W     = 2,
  parameter int GHR_W     = 0,
  parameter int BACK_HINT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               lookup_valid,
  input  logic [31:0]        lookup_pc,
  input  logic               back,
  output logic               pred_valid,
  output logic               predicttaken,
  output logic [INDEX_W-1:0] pred_index,
  input  logic               upd_valid,
  input  logic [INDEX_W-1:0] upd_index,
  input  logic               upd_taken,
  output logic               busy
);

  localparam int             ENTRIES = 1 << INDEX_W;
  localparam logic [CTR_W-1:0] MID   = CTR_W'(1 << (CTR_W - 1));

  bp_state_t          state;
  logic [INDEX_W-1:0] init_ptr;
  logic [CTR_W-1:0]   ctr_table [ENTRIES];
  logic [INDEX_W-1:0] ghr_ext;
  logic [INDEX_W-1:0] idx;
  logic [CTR_W-1:0]   upd_next;
  logic               upd_en;
  logic               unused_pc_bits;

  assign busy           = (state == INIT);
  assign upd_en         = (state == READY) && upd_valid;
  assign idx            = lookup_pc[INDEX_W+1:2] ^ ghr_ext;
  assign unused_pc_bits = ^{lookup_pc[31:INDEX_W+2], lookup_pc[1:0]};

  generate
    if (GHR_W > 0) begin : g_gshare
      logic [GHR_W-1:0] ghr;
      // Low-bit truncation of the concatenation also covers the one-bit history.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) ghr <= '0;
        else if (upd_en) ghr <= GHR_W'({ghr, upd_taken});
      end
      assign ghr_ext = INDEX_W'(ghr);
    end else begin : g_bimodal
      assign ghr_ext = '0;
    end
  endgenerate

  bp_sat_ctr #(.CTR_W(CTR_W)) u_sat_ctr (
    .ctr      (ctr_table[upd_index]),
    .taken    (upd_taken),
    .ctr_next (upd_next)
  );

  // Storage carries no reset; the INIT sweep establishes every entry.
  always_ff @(posedge clk) begin
    if (state == INIT) ctr_table[init_ptr] <= MID;
    else if (upd_valid) ctr_table[upd_index] <= upd_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= INIT;
      init_ptr     <= '0;
      pred_valid   <= 1'b0;
      predicttaken <= 1'b0;
      pred_index   <= '0;
    end else begin
      case (state)
        INIT: begin
          pred_valid <= 1'b0;
          init_ptr   <= init_ptr + 1'b1;
          if (init_ptr == INDEX_W'(ENTRIES - 1)) state <= READY;
        end
        READY: begin
          pred_valid <= lookup_valid;
          if (lookup_valid) begin
            pred_index   <= idx;
            predicttaken <= predict(32'(ctr_table[idx]), back, CTR_W, BACK_HINT != 0);
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_predictor_table.sv
// Directed bench: a bimodal instance with default parameters plus a gshare
// instance (GHR_W=4) sharing clock and reset.
module tb_branch_predictor_table;

  logic        clk = 1'b0;
  logic        reset;
  logic        lookup_valid, back, upd_valid, upd_taken;
  logic [31:0] lookup_pc;
  logic [5:0]  upd_index;
  logic        pred_valid, predicttaken, busy;
  logic [5:0]  pred_index;

  logic        gs_lookup_valid, gs_back, gs_upd_valid, gs_upd_taken;
  logic [31:0] gs_lookup_pc;
  logic [5:0]  gs_upd_index;
  logic        gs_pred_valid, gs_predicttaken, gs_busy;
  logic [5:0]  gs_pred_index;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_predictor_table dut (
    .clk(clk), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc), .back(back),
    .pred_valid(pred_valid), .predicttaken(predicttaken), .pred_index(pred_index),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
    .busy(busy)
  );

  branch_predictor_table #(.GHR_W(4)) dut_gs (
    .clk(clk), .reset(reset),
    .lookup_valid(gs_lookup_valid), .lookup_pc(gs_lookup_pc), .back(gs_back),
    .pred_valid(gs_pred_valid), .predicttaken(gs_predicttaken), .pred_index(gs_pred_index),
    .upd_valid(gs_upd_valid), .upd_index(gs_upd_index), .upd_taken(gs_upd_taken),
    .busy(gs_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Waits out the init sweep, counting cycles; any pred_valid seen meanwhile is flagged.
  task automatic wait_init(output int cyc, output bit pv_seen);
    cyc = 0;
    pv_seen = 1'b0;
    while (busy && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (pred_valid || gs_pred_valid) pv_seen = 1'b1;
    end
    lookup_valid = 1'b0;
    upd_valid    = 1'b0;
    gs_lookup_valid = 1'b0;
    gs_upd_valid    = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic b, input logic exp_t,
                        input logic [5:0] exp_i, input string tag);
    lookup_valid = 1'b1; lookup_pc = pc; back = b;
    @(negedge clk);
    lookup_valid = 1'b0;
    chk({tag, "_valid"}, 32'(pred_valid), 32'd1);
    chk({tag, "_taken"}, 32'(predicttaken), 32'(exp_t));
    chk({tag, "_index"}, 32'(pred_index), 32'(exp_i));
  endtask

  task automatic update(input logic [5:0] i, input logic t, input int n);
    for (int k = 0; k < n; k++) begin
      upd_valid = 1'b1; upd_index = i; upd_taken = t;
      @(negedge clk);
    end
    upd_valid = 1'b0;
  endtask

  task automatic gs_update(input logic t);
    gs_upd_valid = 1'b1; gs_upd_index = 6'd0; gs_upd_taken = t;
    @(negedge clk);
    gs_upd_valid = 1'b0;
  endtask

  int cyc;
  bit pv_seen;

  initial begin
    reset = 1'b1;
    lookup_valid = 0; lookup_pc = 0; back = 0; upd_valid = 0; upd_index = 0; upd_taken = 0;
    gs_lookup_valid = 0; gs_lookup_pc = 0; gs_back = 0;
    gs_upd_valid = 0; gs_upd_index = 0; gs_upd_taken = 0;
    repeat (2) @(negedge clk);
    chk("rst_pred_valid", 32'(pred_valid), 32'd0);
    chk("rst_predicttaken", 32'(predicttaken), 32'd0);
    chk("rst_pred_index", 32'(pred_index), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);

    // Traffic during init must be ignored by both instances.
    lookup_valid = 1'b1; lookup_pc = 32'h40;
    gs_lookup_valid = 1'b1; gs_lookup_pc = 32'h40;
    gs_upd_valid = 1'b1; gs_upd_taken = 1'b1;
    reset = 1'b0;
    wait_init(cyc, pv_seen);
    chk("init_cycles", 32'(cyc), 32'd64);
    chk("init_no_pred_valid", 32'(pv_seen), 32'd0);
    chk("gs_busy_done", 32'(gs_busy), 32'd0);

    // Gshare: history untouched by init traffic, then 1,0,1,1 -> 4'b1011.
    gs_lookup_valid = 1'b1; gs_lookup_pc = 32'h40; gs_back = 1'b0;
    @(negedge clk);
    gs_lookup_valid = 1'b0;
    chk("gs_idx_ghr0", 32'(gs_pred_index), 32'd16);
    gs_update(1'b1); gs_update(1'b0); gs_update(1'b1); gs_update(1'b1);
    gs_lookup_valid = 1'b1;
    @(negedge clk);
    gs_lookup_valid = 1'b0;
    chk("gs_idx_ghr1011", 32'(gs_pred_index), 32'd27);
    chk("gs_valid", 32'(gs_pred_valid), 32'd1);
    chk("gs_taken_mid", 32'(gs_predicttaken), 32'd0);

    // First lookups after init: entry at MID, hint decides.
    lookup(32'h40, 1'b0, 1'b0, 6'd16, "init_b0");
    lookup(32'h40, 1'b1, 1'b1, 6'd16, "init_b1");
    @(negedge clk);
    chk("pred_valid_one_cycle", 32'(pred_valid), 32'd0);

    // Saturate up at index 16.
    update(6'd16, 1'b1, 5);
    lookup(32'h40, 1'b0, 1'b1, 6'd16, "sat_up_max");
    update(6'd16, 1'b0, 1);
    lookup(32'h40, 1'b0, 1'b0, 6'd16, "sat_up_mid_b0");
    lookup(32'h40, 1'b1, 1'b1, 6'd16, "sat_up_mid_b1");

    // Saturate down at index 5.
    update(6'd5, 1'b0, 4);
    lookup(32'h14, 1'b1, 1'b0, 6'd5, "sat_dn_zero");
    update(6'd5, 1'b0, 1);
    update(6'd5, 1'b1, 1);
    lookup(32'h14, 1'b1, 1'b0, 6'd5, "sat_dn_one");
    update(6'd5, 1'b1, 1);
    lookup(32'h14, 1'b1, 1'b1, 6'd5, "sat_dn_mid_b1");
    lookup(32'h14, 1'b0, 1'b0, 6'd5, "sat_dn_mid_b0");

    // Same-cycle update and lookup at index 9: lookup sees the old counter.
    upd_valid = 1'b1; upd_index = 6'd9; upd_taken = 1'b1;
    lookup(32'h24, 1'b0, 1'b0, 6'd9, "rdw_old");
    upd_valid = 1'b0;
    lookup(32'h24, 1'b0, 1'b1, 6'd9, "rdw_new");

    // Reset while READY and trained; updates/lookups during re-init ignored.
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready_busy", 32'(busy), 32'd1);
    chk("rst_ready_pv", 32'(pred_valid), 32'd0);
    reset = 1'b0;
    lookup_valid = 1'b1; lookup_pc = 32'h24;
    upd_valid = 1'b1; upd_index = 6'd16; upd_taken = 1'b1;
    wait_init(cyc, pv_seen);
    chk("reinit_cycles", 32'(cyc), 32'd64);
    chk("reinit_no_pred_valid", 32'(pv_seen), 32'd0);
    lookup(32'h24, 1'b0, 1'b0, 6'd9, "reinit_idx9_mid");
    lookup(32'h40, 1'b0, 1'b0, 6'd16, "reinit_idx16_mid");
    lookup(32'h40, 1'b1, 1'b1, 6'd16, "reinit_idx16_b1");

    // Gshare history cleared by the reset as well.
    gs_lookup_valid = 1'b1; gs_lookup_pc = 32'h40;
    @(negedge clk);
    gs_lookup_valid = 1'b0;
    chk("gs_ghr_cleared", 32'(gs_pred_index), 32'd16);

    // Reset in the middle of the init sweep restarts from entry 0.
    update(6'd3, 1'b1, 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_init(cyc, pv_seen);
    chk("midinit_cycles", 32'(cyc), 32'd64);
    lookup(32'h0C, 1'b0, 1'b0, 6'd3, "midinit_idx3_mid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predictor_table.md
# branch_predictor_table

Parametrised branch direction predictor for the single-cycle/pipelined MIPS fetch stage: a table of 2^INDEX_W saturating counters indexed by PC (bimodal) or PC XOR global history (gshare). Lookups return a registered prediction one cycle later, along with the index used. The execute stage returns that index with the resolved outcome to train the entry. A built-in init sequencer walks every entry to the midpoint after reset. The backward-branch hint resolves the midpoint state.

## Interface

Parameters:
- INDEX_W, 6: table index width; 2^INDEX_W entries.
- CTR_W, 2: counter width, ≥2; MAX = 2^CTR_W−1, MID = 2^(CTR_W−1).
- GHR_W, 0: global history bits, 0..INDEX_W; 0 selects bimodal mode.
- BACK_HINT, 1: 1 means the counter at MID predicts taken iff `back`; 0 means MID predicts not taken.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- lookup_valid  in  1  lookup request this cycle.
- lookup_pc  in  32  branch PC; bits [INDEX_W+1:2] used.
- back  in  1  branch is backward (negative offset); sampled with the lookup.
- pred_valid  out  1  registered; high one cycle after an accepted lookup.
- predicttaken  out  1  registered prediction.
- pred_index  out  INDEX_W  registered index used; the caller carries it to update.
- upd_valid  in  1  resolved branch this cycle.
- upd_index  in  INDEX_W  index returned from pred_index.
- upd_taken  in  1  actual outcome.
- busy  out  1  high while the init sequencer runs.

## Operation

- FSM with two states, INIT and READY.
  - Reset forces INIT, init_ptr=0, ghr=0.
  - In INIT, each cycle writes MID to entry init_ptr and increments init_ptr. After the write to entry 2^INDEX_W−1 the FSM moves to READY.
  - busy = (state==INIT).
- Index:
  - Bimodal: idx = lookup_pc[INDEX_W+1:2].
  - Gshare: idx = lookup_pc[INDEX_W+1:2] XOR {zeros, ghr}, with ghr zero-extended to INDEX_W.
- Prediction rule, for counter value c: taken if c > MID, or if c == MID && back && BACK_HINT. Otherwise not taken.
- Update, only in READY with upd_valid:
  - upd_taken=1 writes c+1, saturating at MAX.
  - upd_taken=0 writes c−1, saturating at 0.
  - When GHR_W>0: ghr <= {ghr[GHR_W−2:0], upd_taken}.
- In INIT, lookups and updates are ignored: pred_valid stays 0 and ghr is not shifted.
- Read-during-write to the same index: the lookup returns the old (pre-update) counter value.
- Gshare uses the ghr value present in the lookup cycle. An update in the same cycle affects only later lookups.
- Reset mid-operation restarts INIT from entry 0 and clears ghr and all outputs.

## Timing

- Reset values: pred_valid=0, predicttaken=0, pred_index=0, busy=1.
- Init lasts exactly 2^INDEX_W cycles after reset deasserts. busy falls on the following edge, and the first lookup is accepted in that cycle.
- Lookup latency is 1 cycle: a request at edge N produces pred_valid/predicttaken/pred_index valid after edge N+1. pred_valid is high for exactly one cycle per lookup.
- Throughput is one lookup plus one update per cycle, every cycle.
- Updates take effect at the next edge. A lookup one cycle after an update to the same index sees the new value.

## Structure

- Package bp_pkg holds:
  - typedef enum logic {INIT, READY} bp_state_t;
  - the function sat_next(c, taken) parametrised via CTR_W;
  - the function predict(c, back).
- Sub-module bp_sat_ctr: combinational next-counter logic with saturation, instantiated on the update path.
- Counter storage is a flat array: logic [CTR_W−1:0] table[2^INDEX_W].

## Test plan

- **Init:** reset, then count cycles. busy is high for exactly 64 cycles with default parameters. The first lookup of PC 0x40, back=0, then returns predicttaken=0. The same lookup with back=1 returns 1.
- **Saturate up:** 5 taken updates to index 16 → counter=3 (MAX), lookup predicts 1. One not-taken update → counter 2, prediction follows `back`.
- **Saturate down:** 4 not-taken updates to index 5 → counter 0, lookup predicts 0. A further not-taken update leaves it at 0. Two taken updates → counter 2 (MID).
- **Gshare (GHR_W=4):** updates with outcomes 1,0,1,1 give ghr=4'b1011. Lookup of PC 0x40 (base index 16) → pred_index=27.
- **Same-cycle update and lookup:** at index 9 with counter 2, an update with taken=1 and a lookup with back=0 in the same cycle return 0. The next lookup returns 1.
- **Ignore during init:** updates and lookups during busy produce no pred_valid and no ghr change. Asserting reset mid-init, or while READY after training, restores busy for 64 cycles and all entries to MID.
